// File: rtl/rvfi_trace_queue_pkg.sv
// Shared types for the RVFI retirement trace queue: record layout, order index and
// a small popcount helper sized for the widest supported commit width.
package rvfi_trace_queue_pkg;

  localparam int unsigned MaxPorts = 4;
  localparam int unsigned CntW     = 3;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [63:0]     order_t;

  // Reference layout of one 256-bit retirement record.
  typedef struct packed {
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [31:0] insn;
    logic [63:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [9:0]  reserved;
  } rvfi_rec_t;

  localparam int unsigned RvfiRecBits = $bits(rvfi_rec_t);

  function automatic cnt_t popcount(input logic [MaxPorts-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MaxPorts; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rvfi_trace_queue_if.sv
// Producer/consumer bundle of the trace queue: retirement inputs, head-of-queue
// handshake and status.
interface rvfi_trace_queue_if #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned RecWidth      = 256
);
  localparam int unsigned LvlW = $clog2(Depth) + 1;

  logic                                   flush_i;
  logic [NrCommitPorts-1:0]               rec_valid_i;
  logic [NrCommitPorts-1:0][RecWidth-1:0] rec_i;
  logic                                   stall_o;
  logic                                   trace_valid_o;
  logic                                   trace_ready_i;
  logic [RecWidth-1:0]                    trace_o;
  logic [63:0]                            trace_order_o;
  logic [LvlW-1:0]                        level_o;
  logic                                   overflow_o;
  logic [31:0]                            drop_cnt_o;

  modport slave (
    input  flush_i, rec_valid_i, rec_i, trace_ready_i,
    output stall_o, trace_valid_o, trace_o, trace_order_o, level_o, overflow_o, drop_cnt_o
  );

  modport master (
    output flush_i, rec_valid_i, rec_i, trace_ready_i,
    input  stall_o, trace_valid_o, trace_o, trace_order_o, level_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/rvfi_trace_compact.sv
// Combinational compaction of valid commit ports into consecutive slots, lowest
// port index first, plus the number of valid ports.
module rvfi_trace_compact
  import rvfi_trace_queue_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned RecWidth      = 256
) (
  input  logic [NrCommitPorts-1:0]               valid_i,
  input  logic [NrCommitPorts-1:0][RecWidth-1:0] rec_i,
  output logic [NrCommitPorts-1:0][RecWidth-1:0] slot_o,
  output cnt_t                                   count_o
);

  cnt_t rank;

  always_comb begin
    slot_o = '0;
    rank   = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (valid_i[i]) begin
        for (int j = 0; j < NrCommitPorts; j++) begin
          if (rank == cnt_t'(j)) begin
            slot_o[j] = rec_i[i];
          end
        end
        rank = rank + cnt_t'(1);
      end
    end
  end

  assign count_o = popcount(MaxPorts'(valid_i));

endmodule

// File: rtl/rvfi_trace_queue.sv
// RVFI retirement trace queue: compacts multi-port retirements into a circular
// flop buffer, tags each with a 64-bit order index and drops whole cycles on overflow.
module rvfi_trace_queue
  import rvfi_trace_queue_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned RecWidth      = 256,
  parameter bit          DropOnFull    = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  rvfi_trace_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  // Both modes discard an overfull cycle; without DropOnFull the upstream is
  // expected to honour stall_o, so a drop there marks a protocol violation.
  logic unused_drop_mode;
  assign unused_drop_mode = DropOnFull;

  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [LvlW-1:0]     level_q, level_d;
  order_t              order_q, order_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         drop_cnt_q, drop_cnt_d;
  logic [RecWidth-1:0] data_q [Depth];
  logic [RecWidth-1:0] data_d [Depth];
  order_t              ord_q [Depth];
  order_t              ord_d [Depth];

  logic [NrCommitPorts-1:0][RecWidth-1:0] slot_rec;
  cnt_t                                   push_cnt;
  logic [LvlW-1:0]                        free;
  logic                                   room_ok, accept, drop, pop;
  logic [32:0]                            drop_sum;

  rvfi_trace_compact #(
    .NrCommitPorts(NrCommitPorts),
    .RecWidth     (RecWidth)
  ) u_compact (
    .valid_i(bus.rec_valid_i),
    .rec_i  (bus.rec_i),
    .slot_o (slot_rec),
    .count_o(push_cnt)
  );

  // Room is judged on the registered level only; a same-cycle pop never helps.
  assign free    = LvlW'(Depth) - level_q;
  assign room_ok = free >= LvlW'(push_cnt);
  assign accept  = (push_cnt != '0) && room_ok && !bus.flush_i;
  assign drop    = (push_cnt != '0) && !room_ok && !bus.flush_i;
  assign pop     = (level_q != '0) && bus.trace_ready_i && !bus.flush_i;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    order_d    = order_q + order_t'(push_cnt);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    data_d     = data_q;
    ord_d      = ord_q;
    drop_sum   = {1'b0, drop_cnt_q} + 33'(push_cnt);

    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NrCommitPorts; k++) begin
          if (k < int'(push_cnt)) begin
            data_d[tail_q + PtrW'(k)] = slot_rec[k];
            ord_d[tail_q + PtrW'(k)]  = order_q + order_t'(k);
          end
        end
        tail_d  = tail_q + PtrW'(push_cnt);
        level_d = level_d + LvlW'(push_cnt);
      end
      if (pop) begin
        head_d  = head_q + PtrW'(1);
        level_d = level_d - LvlW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      order_q    <= order_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; level gates its visibility.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    ord_q  <= ord_d;
  end

  assign bus.trace_valid_o = level_q != '0;
  assign bus.trace_o       = data_q[head_q];
  assign bus.trace_order_o = ord_q[head_q];
  assign bus.level_o       = level_q;
  assign bus.stall_o       = free < LvlW'(NrCommitPorts);
  assign bus.overflow_o    = overflow_q;
  assign bus.drop_cnt_o    = drop_cnt_q;

endmodule
